acc_exec: RTL and testbench
===========================

# acc_exec

Accumulator/flags execution sequencer that sits directly upstream and downstream of the SAP-2 combinational ALU. It owns the accumulator (ACC), the temporary operand register (TMP) and the C/Z/S flags. It drives the ALU's A/B/cin/op inputs, captures the ALU's out/cout, and writes the result back into ACC and the flags through a three-cycle start/done handshake.

## Interface
- No parameters; all datapaths are fixed at 8 bits and the opcode at 4 bits.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request an operation; sampled only in IDLE
- op  in  4  ALU opcode; same encoding as the ALU (0000 ADD … 1011 PASS B)
- operand  in  8  B operand, captured into TMP on an accepted start
- use_carry  in  1  for ADD/SUB only: 1 selects cin = C (ADC/SBB), 0 selects cin = 0
- acc_load  in  1  direct load ACC <= operand (MVI A); honoured only in IDLE with start = 0
- alu_out  in  8  ALU result
- alu_cout  in  1  ALU carry/borrow out
- alu_a  out  8  = ACC
- alu_b  out  8  = TMP
- alu_cin  out  1  registered cin for the current operation
- alu_op  out  4  registered opcode; reset value 1010 (PASS A)
- acc  out  8  accumulator
- flag_c, flag_z, flag_s  out  1 each  carry, zero and sign flags
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- The FSM has four states: IDLE, EXEC, CAPT and WB.
- **IDLE to EXEC** on start = 1:
  - TMP <= operand and alu_op <= op.
  - alu_cin <= flag_c for RAL/RAR; flag_c & use_carry for ADD/SUB; 0 for all other opcodes.
- **EXEC to CAPT** unconditionally. The ALU inputs are held stable for one full cycle.
- **CAPT to WB** unconditionally. RES <= alu_out and RCY <= alu_cout.
- **WB to IDLE** unconditionally. Writeback is applied and done = 1 for that one cycle.
- Writeback rules, by opcode:
  - ADD, SUB: ACC <= RES; C <= RCY; Z <= (RES == 0); S <= RES[7].
  - AND, OR, XOR: ACC <= RES; C <= 0; Z and S updated from RES.
  - NOT: ACC <= RES; flags unchanged.
  - INC, DEC: ACC <= RES; Z and S updated; C unchanged.
  - RAL, RAR: ACC <= RES; C <= RCY; Z and S unchanged.
  - PASS A: no state change (NOP).
  - PASS B: ACC <= RES (MOV); flags unchanged.
  - 1100–1111: no ACC or flag change; done still pulses.
- **IDLE with acc_load = 1 and start = 0:** ACC <= operand; flags unchanged; no done pulse.
- **start and acc_load together in IDLE:** start wins; acc_load is ignored.
- **start while busy:** ignored. It is not queued, and op/operand changes have no effect on the operation in flight.
- **Reset:**
  - ACC = 0, TMP = 0, RES = 0, RCY = 0, C = Z = S = 0.
  - alu_cin = 0, alu_op = 1010, state = IDLE, busy = 0, done = 0.
- **Reset mid-operation:** the operation aborts with no writeback and no done pulse. Registers take their reset values immediately (asynchronous).

## Timing
- An accepted start is sampled at edge k.
- busy = 1 from after edge k until after edge k+3.
- RES is captured at edge k+2.
- ACC and flags update at edge k+3. done = 1 for the cycle between edges k+3 and k+4.
- Start-to-done latency is 3 clocks. The next start is accepted at edge k+4 at the earliest (one IDLE cycle after WB), so throughput is one operation per 4 clocks.
- All outputs are registered except alu_a and alu_b, which are direct register outputs of ACC and TMP; there is no combinational path from any input to any output.
- An acc_load sampled at edge j is visible on acc after edge j.

## Test plan
- ADD: acc_load 0x3C, then start op=0000, operand=0x44, use_carry=0 -> done 3 clocks after start; acc = 0x80, S=1, Z=0, C=0.
- SUB borrow: ACC=0x10, op=0001, operand=0x20 -> acc = 0xF0, C=1, S=1, Z=0. Then INC on ACC=0xFF -> acc = 0x00, Z=1, C still 1.
- ADC: C=1, ACC=0xFF, op=0000, operand=0x00, use_carry=1 -> acc = 0x00, C=1, Z=1, S=0. Repeat with use_carry=0 -> acc = 0xFF, C=0, S=1.
- RAL through carry: C=1, ACC=0x80, op=1000 -> acc = 0x01, C=1, Z and S unchanged. Then RAR with C=1, ACC=0x01 -> acc = 0x80, C=1.
- Handshake:
  - Pulse start again during EXEC and WB with different op/operand -> ignored; exactly one done.
  - start plus acc_load together in IDLE -> start executes and ACC is not loaded from acc_load.
  - Opcode 1110 -> done pulses, with ACC and flags unchanged.
- Reset mid-op: assert rst during CAPT -> acc = 0, flags = 0, busy = 0 immediately, and no done pulse after release.

Source files
------------

// File: rtl/acc_exec_if.sv
// Signal bundle between the accumulator sequencer, its requester and the SAP-2 ALU.
// slave is the sequencer side; master is the requester/ALU side.
interface acc_exec_if;
    logic       start;
    logic [3:0] op;
    logic [7:0] operand;
    logic       use_carry;
    logic       acc_load;
    logic [7:0] alu_out;
    logic       alu_cout;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_op;
    logic [7:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       flag_s;
    logic       busy;
    logic       done;

    modport slave (
        input  start, op, operand, use_carry, acc_load, alu_out, alu_cout,
        output alu_a, alu_b, alu_cin, alu_op, acc, flag_c, flag_z, flag_s, busy, done
    );

    modport master (
        output start, op, operand, use_carry, acc_load, alu_out, alu_cout,
        input  alu_a, alu_b, alu_cin, alu_op, acc, flag_c, flag_z, flag_s, busy, done
    );
endinterface

// File: rtl/acc_exec.sv
// Accumulator/flags sequencer around the SAP-2 combinational ALU: owns ACC, TMP and C/Z/S,
// and runs each operation through IDLE -> EXEC -> CAPT -> WB with a one-cycle done pulse.
module acc_exec (
    input  logic       clk,
    input  logic       rst,
    acc_exec_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        WB   = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_INC   = 4'h6,
        OP_DEC   = 4'h7,
        OP_RAL   = 4'h8,
        OP_RAR   = 4'h9,
        OP_PASSA = 4'hA,
        OP_PASSB = 4'hB
    } op_e;

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] tmp_q, tmp_d;
    logic [7:0] res_q, res_d;
    logic       rcy_q, rcy_d;
    logic       c_q, c_d;
    logic       z_q, z_d;
    logic       s_q, s_d;
    logic       cin_q, cin_d;
    logic [3:0] op_q, op_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       res_zero;
    logic       res_sign;

    assign res_zero = (res_q == 8'h00);
    assign res_sign = res_q[7];

    always_comb begin
        // NOTE: every next-state value defaults to its current register first, so no branch
        // below can leave a signal unassigned and infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        tmp_d   = tmp_q;
        res_d   = res_q;
        rcy_d   = rcy_q;
        c_d     = c_q;
        z_d     = z_q;
        s_d     = s_q;
        cin_d   = cin_q;
        op_d    = op_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tmp_d   = bus.operand;
                    op_d    = bus.op;
                    state_d = EXEC;
                    case (bus.op)
                        OP_ADD, OP_SUB: cin_d = c_q & bus.use_carry;
                        OP_RAL, OP_RAR: cin_d = c_q;
                        default:        cin_d = 1'b0;
                    endcase
                end else if (bus.acc_load) begin
                    acc_d = bus.operand;
                end
            end

            // ALU inputs are held for this whole cycle before the result is sampled.
            EXEC: state_d = CAPT;

            CAPT: begin
                res_d   = bus.alu_out;
                rcy_d   = bus.alu_cout;
                state_d = WB;
            end

            WB: begin
                done_d  = 1'b1;
                state_d = IDLE;
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        acc_d = res_q;
                        c_d   = rcy_q;
                        z_d   = res_zero;
                        s_d   = res_sign;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        acc_d = res_q;
                        c_d   = 1'b0;
                        z_d   = res_zero;
                        s_d   = res_sign;
                    end
                    OP_INC, OP_DEC: begin
                        acc_d = res_q;
                        z_d   = res_zero;
                        s_d   = res_sign;
                    end
                    OP_RAL, OP_RAR: begin
                        acc_d = res_q;
                        c_d   = rcy_q;
                    end
                    OP_NOT, OP_PASSB: acc_d = res_q;
                    // PASS A and the unassigned opcodes still complete but change nothing.
                    default: ;
                endcase
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 8'h00;
            tmp_q   <= 8'h00;
            res_q   <= 8'h00;
            rcy_q   <= 1'b0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            s_q     <= 1'b0;
            cin_q   <= 1'b0;
            op_q    <= OP_PASSA;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tmp_q   <= tmp_d;
            res_q   <= res_d;
            rcy_q   <= rcy_d;
            c_q     <= c_d;
            z_q     <= z_d;
            s_q     <= s_d;
            cin_q   <= cin_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.alu_a   = acc_q;
    assign bus.alu_b   = tmp_q;
    assign bus.alu_cin = cin_q;
    assign bus.alu_op  = op_q;
    assign bus.acc     = acc_q;
    assign bus.flag_c  = c_q;
    assign bus.flag_z  = z_q;
    assign bus.flag_s  = s_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_acc_exec.sv
// Scoreboard bench for acc_exec: a bit-level SAP-2 ALU closes the loop, an integer-level
// reference model predicts each writeback, and a monitor checks every done pulse.
module tb_acc_exec;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;

    acc_exec_if bus ();

    acc_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational SAP-2 ALU the sequencer drives and captures from.
    logic [8:0] alu_t;
    always_comb begin
        alu_t        = 9'h000;
        bus.alu_out  = 8'h00;
        bus.alu_cout = 1'b0;
        case (bus.alu_op)
            4'h0: begin alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'h00, bus.alu_cin};
                        bus.alu_out = alu_t[7:0]; bus.alu_cout = alu_t[8]; end
            4'h1: begin alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'h00, bus.alu_cin};
                        bus.alu_out = alu_t[7:0]; bus.alu_cout = alu_t[8]; end
            4'h2: bus.alu_out = bus.alu_a & bus.alu_b;
            4'h3: bus.alu_out = bus.alu_a | bus.alu_b;
            4'h4: bus.alu_out = bus.alu_a ^ bus.alu_b;
            4'h5: bus.alu_out = ~bus.alu_a;
            4'h6: bus.alu_out = bus.alu_a + 8'h01;
            4'h7: bus.alu_out = bus.alu_a - 8'h01;
            4'h8: begin bus.alu_out = {bus.alu_a[6:0], bus.alu_cin}; bus.alu_cout = bus.alu_a[7]; end
            4'h9: begin bus.alu_out = {bus.alu_cin, bus.alu_a[7:1]}; bus.alu_cout = bus.alu_a[0]; end
            4'hA: bus.alu_out = bus.alu_a;
            4'hB: bus.alu_out = bus.alu_b;
            default: begin bus.alu_out = 8'hA5; bus.alu_cout = 1'b1; end
        endcase
    end

    typedef struct {
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       s;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    int   m_acc;
    bit   m_c, m_z, m_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_z = 0; m_s = 0;
    endtask

    task automatic set_result(input int v, input bit upd_zs);
        m_acc = v & 255;
        if (upd_zs) begin
            m_z = (m_acc == 0);
            m_s = (m_acc >= 128);
        end
    endtask

    // Reference behaviour of one accepted operation in plain integer arithmetic.
    task automatic model_exec(input int o, input int b, input bit uc, output bit cin);
        int a;
        int r;
        a   = m_acc;
        cin = 1'b0;
        case (o)
            0: begin cin = uc & m_c; r = a + b + int'(cin); m_c = (r > 255); set_result(r, 1); end
            1: begin cin = uc & m_c; r = a - b - int'(cin); m_c = (r < 0);   set_result(r, 1); end
            2: begin m_c = 0; set_result(a & b, 1); end
            3: begin m_c = 0; set_result(a | b, 1); end
            4: begin m_c = 0; set_result(a ^ b, 1); end
            5: set_result(255 - a, 0);
            6: set_result(a + 1, 1);
            7: set_result(a - 1, 1);
            8: begin cin = m_c; r = a * 2 + int'(m_c); m_c = (a >= 128); set_result(r, 0); end
            9: begin cin = m_c; r = a / 2 + (m_c ? 128 : 0); m_c = (a % 2 == 1); set_result(r, 0); end
            11: set_result(b, 0);
            default: ;
        endcase
    endtask

    // Monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("wb_acc", {24'h0, bus.acc}, {24'h0, e.acc});
                check("wb_flags", {29'h0, bus.flag_c, bus.flag_z, bus.flag_s}, {29'h0, e.c, e.z, e.s});
                check("busy_in_done", {31'h0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic drive_idle();
        bus.start = 1'b0; bus.acc_load = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        bus.start = 1'b0; bus.acc_load = 1'b1; bus.operand = v;
        bus.op = 4'($urandom_range(0, 15));
        m_acc = int'(v);
        @(negedge clk);
        drive_idle();
        check("load_acc", {24'h0, bus.acc}, {24'h0, v});
        check("load_flags", {29'h0, bus.flag_c, bus.flag_z, bus.flag_s}, {29'h0, m_c, m_z, m_s});
    endtask

    task automatic do_op(input logic [3:0] o, input logic [7:0] b, input bit uc,
                         input bit noise, input bit load_too);
        bit   cin;
        exp_t e;
        int   n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.operand = b; bus.use_carry = uc; bus.acc_load = load_too;
        model_exec(int'(o), int'(b), uc, cin);
        e.acc = 8'(m_acc); e.c = m_c; e.z = m_z; e.s = m_s; e.cyc = cyc + 4;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check("busy_after_start", {31'h0, bus.busy}, 32'd1);
        check("alu_op_latched", {28'h0, bus.alu_op}, {28'h0, o});
        check("alu_b_latched", {24'h0, bus.alu_b}, {24'h0, b});
        check("alu_cin_latched", {31'h0, bus.alu_cin}, {31'h0, cin});
        @(negedge clk);  // EXEC
        if (noise) begin
            bus.start = 1'b1; bus.acc_load = 1'b1; bus.op = 4'($urandom_range(0, 15));
            bus.operand = 8'($urandom); bus.use_carry = 1'($urandom);
        end else drive_idle();
        @(negedge clk);  // CAPT
        drive_idle();
        @(negedge clk);  // WB
        if (noise) begin
            bus.start = 1'b1; bus.acc_load = 1'b1; bus.op = 4'($urandom_range(0, 15));
            bus.operand = 8'($urandom);
        end
        @(negedge clk);  // done cycle
        drive_idle();
        n = 0;
        while (sb_q.size() != 0 && n < 8) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    task automatic check_state(input string name, input logic [7:0] a, input bit c, input bit z, input bit s);
        @(negedge clk);
        check(name, {20'h0, bus.acc, 1'b0, bus.flag_c, bus.flag_z, bus.flag_s}, {20'h0, a, 1'b0, c, z, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.op = 4'h0; bus.operand = 8'h00; bus.use_carry = 1'b0; bus.acc_load = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_acc", {24'h0, bus.acc}, 32'h0);
        check("rst_flags", {29'h0, bus.flag_c, bus.flag_z, bus.flag_s}, 32'h0);
        check("rst_busy_done", {30'h0, bus.busy, bus.done}, 32'h0);
        check("rst_alu_op", {28'h0, bus.alu_op}, 32'hA);
        check("rst_alu_cin_b", {23'h0, bus.alu_cin, bus.alu_b}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ADD
        do_load(8'h3C);
        do_op(4'h0, 8'h44, 1'b0, 1'b0, 1'b0);
        check_state("tp_add", 8'h80, 1'b0, 1'b0, 1'b1);
        // SUB with borrow, then INC wrapping to zero
        do_load(8'h10);
        do_op(4'h1, 8'h20, 1'b0, 1'b0, 1'b0);
        check_state("tp_sub_borrow", 8'hF0, 1'b1, 1'b0, 1'b1);
        do_load(8'hFF);
        do_op(4'h6, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("tp_inc_wrap", 8'h00, 1'b1, 1'b1, 1'b0);
        // ADC with and without use_carry
        do_load(8'hFF);
        do_op(4'h0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_state("tp_adc", 8'h00, 1'b1, 1'b1, 1'b0);
        do_load(8'hFF);
        do_op(4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("tp_add_nocarry", 8'hFF, 1'b0, 1'b0, 1'b1);
        // RAL/RAR through carry (C set by 0x00 - 0x01)
        do_load(8'h00);
        do_op(4'h1, 8'h01, 1'b0, 1'b0, 1'b0);
        do_load(8'h80);
        do_op(4'h8, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("tp_ral", 8'h01, 1'b1, 1'b0, 1'b1);
        do_op(4'h9, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state("tp_rar", 8'h80, 1'b1, 1'b0, 1'b1);
        // Start pulses and loads while busy are ignored
        do_op(4'h3, 8'h0F, 1'b0, 1'b1, 1'b0);
        check_state("tp_busy_ignore", 8'h8F, 1'b0, 1'b0, 1'b1);
        // start and acc_load together: start wins
        do_op(4'h4, 8'hFF, 1'b0, 1'b0, 1'b1);
        check_state("tp_start_over_load", 8'h70, 1'b0, 1'b0, 1'b0);
        // Unassigned opcode: done pulses, nothing changes
        do_op(4'hE, 8'h12, 1'b1, 1'b0, 1'b0);
        check_state("tp_op_1110", 8'h70, 1'b0, 1'b0, 1'b0);

        // Reset asserted during CAPT aborts the operation
        do_load(8'h5A);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'h0; bus.operand = 8'hC0; bus.use_carry = 1'b0;
        @(posedge clk);  // accepted -> EXEC
        @(negedge clk);
        drive_idle();
        @(posedge clk);  // -> CAPT
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_acc", {24'h0, bus.acc}, 32'h0);
        check("midrst_flags_busy_done", {27'h0, bus.flag_c, bus.flag_z, bus.flag_s, bus.busy, bus.done}, 32'h0);
        model_reset();
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_idle_after", {23'h0, bus.busy, bus.acc}, 32'h0);

        // Randomised mix of loads, operations, busy-time noise and start+load collisions
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) do_load(8'($urandom));
            else do_op(4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom), r == 1, r == 2);
        end
        check_state("final_state", 8'(m_acc), m_c, m_z, m_s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
